e_mdu: RTL and testbench

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu.sv | 158 +++++++++++++++
 tb/tb_e_mdu.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle mult/multu/div/divu with HI/LO registers.
// Results are computed from operands latched at issue and written when the busy count ends.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic        Occupied,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles < 2) ? 1 : $clog2(MaxCycles + 1);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;

    typedef enum logic [1:0] {StIdle, StMult, StDiv} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic              signed_q, signed_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;

    logic              is_mult_op;
    logic              is_div_op;
    logic              accept;
    logic              done;

    logic [63:0]       prod;
    logic [31:0]       abs_a, abs_b, div_b;
    logic [31:0]       uquot, urem, quot, rem;

    // Issue decode shared by the FSM and datapath
    always_comb begin
        is_mult_op = Start && ((MDUOp == OpMult) || (MDUOp == OpMultu));
        is_div_op  = Start && ((MDUOp == OpDiv) || (MDUOp == OpDivu));
        accept     = (state_q == StIdle) && (is_mult_op || is_div_op);
        done       = (state_q != StIdle) && (cnt_q <= CntW'(1));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (is_mult_op) begin
                    state_d = StMult;
                end else if (is_div_op) begin
                    state_d = StDiv;
                end
            end
            StMult, StDiv: begin
                if (done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: Occupied lets the hazard unit stall D in the same cycle a mult/div issues
    always_comb begin
        Busy     = (state_q != StIdle);
        Occupied = Busy || is_mult_op || is_div_op;
        HI       = hi_q;
        LO       = lo_q;
    end

    // Arithmetic on latched operands; signed ops sign-extend, low 64 bits give the product
    always_comb begin
        prod  = {{32{signed_q & a_q[31]}}, a_q} * {{32{signed_q & b_q[31]}}, b_q};
        abs_a = (signed_q && a_q[31]) ? (32'd0 - a_q) : a_q;
        abs_b = (signed_q && b_q[31]) ? (32'd0 - b_q) : b_q;
        // Divide-by-zero result is discarded; keep the divider well-defined anyway
        div_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
        uquot = abs_a / div_b;
        urem  = abs_a % div_b;
        // Magnitude division avoids the 0x80000000 / -1 overflow case
        quot  = (signed_q && (a_q[31] ^ b_q[31])) ? (32'd0 - uquot) : uquot;
        rem   = (signed_q && a_q[31]) ? (32'd0 - urem) : urem;
    end

    // Datapath next-state: operand latch, countdown, HI/LO writes
    always_comb begin
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (state_q == StIdle) begin
            if (accept) begin
                a_d      = A;
                b_d      = B;
                signed_d = (MDUOp == OpMult) || (MDUOp == OpDiv);
                cnt_d    = is_mult_op ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
            end else if (Start && (MDUOp == OpMthi)) begin
                hi_d = A;
            end else if (Start && (MDUOp == OpMtlo)) begin
                lo_d = A;
            end
        end else if (done) begin
            cnt_d = '0;
            if (state_q == StMult) begin
                {hi_d, lo_d} = prod;
            end else if (b_q != 32'd0) begin
                hi_d = rem;
                lo_d = quot;
            end
        end else begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: vector table plus multi-cycle corner sequences.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic        Occupied;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int errors;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[17];

    e_mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .MDUOp   (MDUOp),
        .Start   (Start),
        .Busy    (Busy),
        .Occupied(Occupied),
        .HI      (HI),
        .LO      (LO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi, input logic [31:0] lo, input int cyc);
        vec_t v;
        v.op  = op;
        v.a   = a;
        v.b   = b;
        v.hi  = hi;
        v.lo  = lo;
        v.cyc = cyc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called just after a negedge; drives one Start cycle and returns at the following negedge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        MDUOp = op;
        A     = a;
        B     = b;
        Start = 1'b1;
        #1;
        check("occupied_at_issue", {31'd0, Occupied}, {31'd0, (op >= 4'd1 && op <= 4'd4)});
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        MDUOp = 4'd0;
    endtask

    // Counts busy negedges, checking HI/LO hold and Occupied stays high; bounded
    task automatic wait_idle(input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                             output int n);
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            check("hi_hold_busy", HI, hold_hi);
            check("lo_hold_busy", LO, hold_lo);
            check("occupied_busy", {31'd0, Occupied}, 32'd1);
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        A       = '0;
        B       = '0;
        MDUOp   = 4'd0;
        Start   = 1'b0;

        vecs[0]  = mk(4'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5);
        vecs[1]  = mk(4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5);
        vecs[2]  = mk(4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        vecs[3]  = mk(4'd4, 32'd7,        32'd2,        32'd1,        32'd3,        10);
        vecs[4]  = mk(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10);
        vecs[5]  = mk(4'd5, 32'hAAAA0000, 32'h5555,     32'hAAAA0000, 32'h80000000, 0);
        vecs[6]  = mk(4'd6, 32'h0000BBBB, 32'h7777,     32'hAAAA0000, 32'h0000BBBB, 0);
        vecs[7]  = mk(4'd3, 32'd5,        32'd0,        32'hAAAA0000, 32'h0000BBBB, 10);
        vecs[8]  = mk(4'd4, 32'd5,        32'd0,        32'hAAAA0000, 32'h0000BBBB, 10);
        vecs[9]  = mk(4'd1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5);
        vecs[10] = mk(4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10);
        vecs[11] = mk(4'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        10);
        vecs[12] = mk(4'd0, 32'h1234,     32'h5678,     32'hFFFFFFFF, 32'd3,        0);
        vecs[13] = mk(4'd9, 32'h1234,     32'h5678,     32'hFFFFFFFF, 32'd3,        0);
        vecs[14] = mk(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
        vecs[15] = mk(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        5);
        vecs[16] = mk(4'd4, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 10);

        // Reset state
        #1;
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_occupied", {31'd0, Occupied}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Vector table
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        for (int i = 0; i < 17; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            // Operand changes while busy must not affect the result
            A = ~vecs[i].a;
            B = vecs[i].b + 32'd3;
            wait_idle(prev_hi, prev_lo, n);
            check($sformatf("vec%0d_busy_cycles", i), n, vecs[i].cyc);
            check($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
            prev_hi = vecs[i].hi;
            prev_lo = vecs[i].lo;
        end

        // Starts while busy are ignored
        issue(4'd1, 32'd3, 32'd4);
        check("ign_busy_c1", {31'd0, Busy}, 32'd1);
        @(negedge clk);
        MDUOp = 4'd6;
        A     = 32'h12345678;
        Start = 1'b1;
        #1;
        check("ign_occ_mtlo", {31'd0, Occupied}, 32'd1);
        @(negedge clk);
        MDUOp = 4'd3;
        A     = 32'd100;
        B     = 32'd7;
        #1;
        check("ign_occ_div", {31'd0, Occupied}, 32'd1);
        check("ign_lo_hold", LO, 32'h19999999);
        @(negedge clk);
        Start = 1'b0;
        MDUOp = 4'd0;
        wait_idle(32'd5, 32'h19999999, n);
        check("ign_remaining_cycles", n, 2);
        check("ign_hi", HI, 32'd0);
        check("ign_lo", LO, 32'd12);
        for (int k = 0; k < 3; k++) begin
            check("ign_no_div_queued", {31'd0, Busy}, 32'd0);
            @(negedge clk);
        end

        // Back-to-back issue in the first non-busy cycle
        issue(4'd1, 32'd3, 32'd5);
        wait_idle(32'd0, 32'd12, n);
        check("b2b_mult_cycles", n, 5);
        check("b2b_mult_lo", LO, 32'd15);
        issue(4'd4, 32'd100, 32'd7);
        check("b2b_busy_again", {31'd0, Busy}, 32'd1);
        wait_idle(32'd0, 32'd15, n);
        check("b2b_div_cycles", n, 10);
        check("b2b_div_hi", HI, 32'd2);
        check("b2b_div_lo", LO, 32'd14);

        // Asynchronous reset mid-operation
        issue(4'd3, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, Busy}, 32'd0);
        check("arst_occupied", {31'd0, Occupied}, 32'd0);
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("arst_no_resume", {31'd0, Busy}, 32'd0);
        end
        check("arst_hi_after", HI, 32'd0);
        check("arst_lo_after", LO, 32'd0);

        // First Start after reset release is taken at the next edge
        #2;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        MDUOp = 4'd5;
        A     = 32'hCAFE0000;
        Start = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_mthi", HI, 32'hCAFE0000);
        check("post_reset_busy", {31'd0, Busy}, 32'd0);
        Start = 1'b0;
        MDUOp = 4'd0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
